// File: rtl/bpm_uart_reporter.sv
// bpm_uart_reporter: captures BPM readings via valid/copied handshake, buffers them and sends "DDD\r\n" over 8N1 UART.
module bpm_uart_reporter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [7:0]                    bpm_value,
  input  logic                          bpm_valid,
  output logic                          bpm_copied,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] C_IDLE = 2'd0, C_ACK = 2'd1, C_REARM = 2'd2;
  localparam logic [1:0] T_IDLE = 2'd0, T_CONV = 2'd1, T_SEND = 2'd2;
  logic [1:0] cstate, tstate;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop, full, empty;
  logic [7:0] val, cur_byte;
  logic [3:0] h, t, bit_cnt;
  logic [2:0] byte_idx;
  logic [BW-1:0] baud;
  assign full = fifo_level == (PW+1)'(FIFO_DEPTH);
  assign empty = fifo_level == '0;
  assign push = cstate == C_IDLE && en && bpm_valid && !full;
  assign pop = tstate == T_IDLE && !empty;
  assign bpm_copied = cstate == C_ACK;
  assign tx_busy = tstate != T_IDLE;
  always_comb begin
    cur_byte = byte_idx == 3'd0 ? 8'h30 + {4'd0, h} :
               byte_idx == 3'd1 ? 8'h30 + {4'd0, t} :
               byte_idx == 3'd2 ? 8'h30 + {4'd0, val[3:0]} :
               byte_idx == 3'd3 ? 8'h0d : 8'h0a;
  end
  always_ff @(posedge clk) begin
    if (rst) cstate <= C_IDLE;
    else cstate <= push ? C_ACK :
                   cstate == C_ACK ? C_REARM :
                   (cstate == C_REARM && !bpm_valid) ? C_IDLE : cstate;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bpm_value;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // uart_tx is loaded with the value of the bit that starts at this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      tstate <= T_IDLE;
      uart_tx <= 1'b1;
      val <= '0;
      h <= '0;
      t <= '0;
      bit_cnt <= '0;
      byte_idx <= '0;
      baud <= '0;
    end else begin
      case (tstate)
        T_IDLE: if (pop) begin
          val <= mem[rd_ptr];
          h <= '0;
          t <= '0;
          tstate <= T_CONV;
        end
        T_CONV: if (val >= 8'd100) begin
          val <= val - 8'd100;
          h <= h + 4'd1;
        end else if (val >= 8'd10) begin
          val <= val - 8'd10;
          t <= t + 4'd1;
        end else begin
          tstate <= T_SEND;
          uart_tx <= 1'b0;
          baud <= '0;
          bit_cnt <= '0;
          byte_idx <= '0;
        end
        T_SEND: if (baud != BW'(CLKS_PER_BIT - 1)) baud <= baud + 1'b1;
        else begin
          baud <= '0;
          if (bit_cnt == 4'd9) begin
            if (byte_idx == 3'd4) begin
              tstate <= T_IDLE;
              uart_tx <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              bit_cnt <= '0;
              uart_tx <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            uart_tx <= bit_cnt == 4'd8 ? 1'b1 : cur_byte[bit_cnt[2:0]];
          end
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bpm_uart_reporter.sv
// tb_bpm_uart_reporter: directed checks of handshake, FIFO backpressure, decimal UART frames and reset.
module tb_bpm_uart_reporter;
  logic clk = 0, rst = 1, en = 1, bpm_valid = 0, bpm_copied, uart_tx, tx_busy;
  logic [7:0] bpm_value = 0, rb;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0, ack_cnt = 0;
  logic [7:0] rx_q [$];
  bpm_uart_reporter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .bpm_value(bpm_value), .bpm_valid(bpm_valid),
    .bpm_copied(bpm_copied), .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  always @(negedge clk) ack_cnt <= ack_cnt + (bpm_copied ? 1 : 0);
  // UART receiver: samples mid-bit, 4 clocks per bit
  initial forever begin
    @(negedge uart_tx);
    repeat (2) @(posedge clk);
    #1;
    if (uart_tx == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(posedge clk);
        #1;
        rb[i] = uart_tx;
      end
      rx_q.push_back(rb);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic handshake(input logic [7:0] v, input int limit, input int hold, output int waits, output int maxl);
    bpm_value = v;
    bpm_valid = 1;
    waits = 0;
    maxl = 0;
    do begin
      @(negedge clk);
      waits++;
      if (int'(fifo_level) > maxl) maxl = fifo_level;
    end while (!bpm_copied && waits < limit);
    chk($sformatf("ack_%0d", v), bpm_copied, 1);
    repeat (hold) begin
      @(negedge clk);
      if (int'(fifo_level) > maxl) maxl = fifo_level;
    end
    bpm_valid = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_idle(output int maxl);
    int n = 0;
    maxl = 0;
    while ((tx_busy || fifo_level != 0) && n < 3000) begin
      @(negedge clk);
      n++;
      if (int'(fifo_level) > maxl) maxl = fifo_level;
    end
    chk("idle", tx_busy, 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_tx(input logic lvl);
    int n = 0;
    while (uart_tx !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_tx", uart_tx, lvl);
  endtask
  task automatic chk_frame(input logic [7:0] v);
    logic [7:0] e [5];
    logic [7:0] b;
    e[0] = 8'h30 + v / 100;
    e[1] = 8'h30 + (v / 10) % 10;
    e[2] = 8'h30 + v % 10;
    e[3] = 8'h0d;
    e[4] = 8'h0a;
    for (int i = 0; i < 5; i++) begin
      b = rx_q.size() > 0 ? rx_q.pop_front() : 8'hxx;
      chk($sformatf("frame_%0d_byte%0d", v, i), b, e[i]);
    end
  endtask
  initial begin
    int w, m, a0, n;
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_copied", bpm_copied, 0);
    rst = 0;
    @(negedge clk);
    // T1: latency, single pulse, busy duration 200 + 8 conversion cycles
    a0 = ack_cnt;
    bpm_value = 72;
    bpm_valid = 1;
    @(negedge clk);
    chk("t1_copied", bpm_copied, 1);
    bpm_valid = 0;
    @(negedge clk);
    chk("t1_pulse", bpm_copied, 0);
    n = 0;
    while (tx_busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", n, 208);
    wait_idle(m);
    chk("t1_acks", ack_cnt - a0, 1);
    chk_frame(72);
    chk("t1_extra", rx_q.size(), 0);
    // T2: valid held long after ack
    a0 = ack_cnt;
    handshake(123, 20, 20, w, m);
    chk("t2_maxlvl_hs", m, 1);
    wait_idle(m);
    chk("t2_maxlvl_tx", m, 0);
    chk("t2_acks", ack_cnt - a0, 1);
    chk_frame(123);
    chk("t2_extra", rx_q.size(), 0);
    // T3: six readings while busy; the sixth is stalled until the first frame ends
    for (int i = 1; i <= 5; i++) begin
      handshake(8'(11 * i), 20, 0, w, m);
      chk("t3_lat", w, 1);
    end
    chk("t3_full", fifo_level, 4);
    handshake(66, 400, 0, w, m);
    chk("t3_withheld", w, 191);
    wait_idle(m);
    for (int i = 1; i <= 6; i++) chk_frame(8'(11 * i));
    chk("t3_extra", rx_q.size(), 0);
    // T4: boundary values
    handshake(0, 20, 0, w, m);
    handshake(100, 20, 0, w, m);
    handshake(255, 20, 0, w, m);
    wait_idle(m);
    chk_frame(0);
    chk_frame(100);
    chk_frame(255);
    chk("t4_extra", rx_q.size(), 0);
    // T5: reset during data bits of the second byte
    handshake(123, 20, 0, w, m);
    handshake(45, 20, 0, w, m);
    n = 0;
    while (rx_q.size() < 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_byte1", rx_q.size(), 1);
    wait_tx(1);
    wait_tx(0);
    repeat (10) @(negedge clk);
    chk("t5_pre_lvl", fifo_level, 1);
    chk("t5_pre_busy", tx_busy, 1);
    rst = 1;
    @(negedge clk);
    chk("t5_tx", uart_tx, 1);
    chk("t5_busy", tx_busy, 0);
    chk("t5_lvl", fifo_level, 0);
    chk("t5_copied", bpm_copied, 0);
    rst = 0;
    repeat (60) @(negedge clk);
    chk("t5_quiet", tx_busy, 0);
    rx_q.delete();
    handshake(89, 20, 0, w, m);
    wait_idle(m);
    chk_frame(89);
    chk("t5_extra", rx_q.size(), 0);
    // T6: capture gated by en
    en = 0;
    a0 = ack_cnt;
    bpm_value = 77;
    bpm_valid = 1;
    repeat (30) @(negedge clk);
    chk("t6_noack", ack_cnt - a0, 0);
    chk("t6_lvl", fifo_level, 0);
    en = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bpm_copied && n < 10);
    chk("t6_ack", bpm_copied, 1);
    chk("t6_lat", n, 1);
    bpm_valid = 0;
    repeat (2) @(negedge clk);
    wait_idle(m);
    chk_frame(77);
    chk("t6_extra", rx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
